scandoubler: RTL and testbench

- Converts 15 kHz core video (RGB 6:6:6 plus HS/VS) to 31 kHz by writing each input line into a line buffer and reading it out twice at double pixel rate.
- Sits directly upstream of the OSD overlay stage and drives that stage's VGA_Rx/Gx/Bx, OSD_HS and OSD_VS inputs.
- Optional scanline effect dims the second (repeat) copy of each line.

---
 rtl/scandoubler_pkg.sv | 14 +
 rtl/scandoubler_line_buffer.sv | 35 +++
 rtl/scandoubler.sv | 155 +++++++++++++++
 tb/tb_scandoubler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared constants and the scanline dimming helper for the 15 kHz -> 31 kHz scandoubler.
package scandoubler_pkg;

  localparam int HCNT_W_DEF  = 10;
  localparam int COLOR_W_DEF = 6;
  localparam int RGB_W       = 3 * COLOR_W_DEF;
  localparam int SD_LAT      = 2;

  // c - c/4: never underflows, so no saturation is needed.
  function automatic logic [COLOR_W_DEF-1:0] sd_dim(input logic [COLOR_W_DEF-1:0] c);
    return c - (c >> 2);
  endfunction

endpackage

// File: rtl/scandoubler_line_buffer.sv
// Two-bank line buffer: one write port, one read port with registered read data.
module sd_line_buffer
  import scandoubler_pkg::*;
#(
  parameter int AW = HCNT_W_DEF + 1,
  parameter int DW = RGB_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Storage array is never cleared; only the read register has a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scandoubler.sv
// Line-doubling scan converter: each input line is written to one bank and the
// previous line is replayed twice at double pixel rate, optionally dimming the repeat.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int HCNT_W  = HCNT_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce_x2,
  input  logic               ce_x1,
  input  logic               scanlines,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               hs_out,
  output logic               vs_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int RW = 3 * COLOR_W;
  localparam logic [HCNT_W-1:0] HMAX = '1;
  localparam logic [HCNT_W-1:0] HONE = {{(HCNT_W-1){1'b0}}, 1'b1};

  logic              hs_d;
  logic [HCNT_W-1:0] hcnt_in;
  logic [HCNT_W-1:0] line_len;
  logic [HCNT_W-1:0] hs_len;
  logic [HCNT_W-1:0] ocnt;
  logic              wr_bank;
  logic              phase;
  logic              hs_rise;
  logic              hs_fall;

  logic [RW-1:0]     rd_data;
  logic              hs_s1;
  logic              vs_s1;
  logic              phase_s1;

  logic [COLOR_W-1:0] r_nx;
  logic [COLOR_W-1:0] g_nx;
  logic [COLOR_W-1:0] b_nx;

  assign hs_rise = ce_x1 & hs_in & ~hs_d;
  assign hs_fall = ce_x1 & ~hs_in & hs_d;

  sd_line_buffer #(
    .AW (HCNT_W + 1),
    .DW (RW)
  ) u_buf (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .we    (ce_x1),
    .waddr ({wr_bank, hcnt_in}),
    .wdata ({r_in, g_in, b_in}),
    .re    (ce_x2),
    .raddr ({~wr_bank, ocnt}),
    .rdata (rd_data)
  );

  // Input side: count pixels, latch line and hsync lengths, swap banks on hsync.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d     <= 1'b0;
      hcnt_in  <= '0;
      line_len <= '0;
      hs_len   <= '0;
      wr_bank  <= 1'b0;
    end else if (ce_x1) begin
      hs_d <= hs_in;
      if (hs_rise) begin
        line_len <= hcnt_in;
        hcnt_in  <= '0;
        wr_bank  <= ~wr_bank;
      end else if (hcnt_in != HMAX) begin
        hcnt_in <= hcnt_in + HONE;
      end
      if (hs_fall) begin
        hs_len <= hcnt_in;
      end
    end
  end

  // Output counter: line_len==0 makes line_len-1 all ones, i.e. a full 2^HCNT_W period.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ocnt  <= '0;
      phase <= 1'b0;
    end else if (ce_x2) begin
      if (hs_rise) begin
        ocnt  <= '0;
        phase <= 1'b0;
      end else if (ocnt == line_len - HONE) begin
        ocnt  <= '0;
        phase <= ~phase;
      end else begin
        ocnt <= ocnt + HONE;
      end
    end
  end

  // Control bits travel alongside the buffer read register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      phase_s1 <= 1'b0;
    end else if (ce_x2) begin
      hs_s1    <= (ocnt < hs_len);
      vs_s1    <= vs_in;
      phase_s1 <= phase;
    end
  end

  always_comb begin
    r_nx = rd_data[RW-1 -: COLOR_W];
    g_nx = rd_data[2*COLOR_W-1 -: COLOR_W];
    b_nx = rd_data[COLOR_W-1:0];
    if (hs_s1) begin
      r_nx = '0;
      g_nx = '0;
      b_nx = '0;
    end else if (scanlines & phase_s1) begin
      r_nx = sd_dim(rd_data[RW-1 -: COLOR_W]);
      g_nx = sd_dim(rd_data[2*COLOR_W-1 -: COLOR_W]);
      b_nx = sd_dim(rd_data[COLOR_W-1:0]);
    end else begin
      r_nx = rd_data[RW-1 -: COLOR_W];
      g_nx = rd_data[2*COLOR_W-1 -: COLOR_W];
      b_nx = rd_data[COLOR_W-1:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else if (ce_x2) begin
      hs_out <= hs_s1;
      vs_out <= vs_s1;
      r_out  <= r_nx;
      g_out  <= g_nx;
      b_out  <= b_nx;
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Randomized bench for scandoubler against a line-buffer/counter reference model.
module tb_scandoubler;

  localparam int CW    = 6;
  localparam int NADDR = 1024;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b1;
  logic          ce_x2 = 1'b0;
  logic          ce_x1 = 1'b0;
  logic          scanlines = 1'b0;
  logic          hs_in = 1'b0;
  logic          vs_in = 1'b0;
  logic [CW-1:0] r_in = '0;
  logic [CW-1:0] g_in = '0;
  logic [CW-1:0] b_in = '0;
  logic          hs_out;
  logic          vs_out;
  logic [CW-1:0] r_out;
  logic [CW-1:0] g_out;
  logic [CW-1:0] b_out;

  always #5 clk_sys = ~clk_sys;

  scandoubler dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_x2     (ce_x2),
    .ce_x1     (ce_x1),
    .scanlines (scanlines),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  int errors = 0;
  int checks = 0;
  int div = 0;
  int seen_30 = 0;
  int seen_03 = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        ph;
    logic        v;
    logic [17:0] c;
  } ent_t;

  int unsigned mem  [2][NADDR];
  bit          memv [2][NADDR];
  int          m_hcnt, m_line_len, m_hs_len, m_ocnt;
  bit          m_wb, m_phase, m_hsd;
  ent_t        pipe [$];
  bit          exp_hs, exp_vs, exp_cv;
  int unsigned exp_c;

  function automatic int unsigned dim_rgb(input int unsigned c);
    int unsigned r, g, b;
    r = (c >> 12) & 63;
    g = (c >> 6) & 63;
    b = c & 63;
    r = r - r / 4;
    g = g - g / 4;
    b = b - b / 4;
    return (r << 12) | (g << 6) | b;
  endfunction

  task automatic model_reset();
    ent_t z;
    z = '0;
    m_hcnt = 0; m_line_len = 0; m_hs_len = 0; m_ocnt = 0;
    m_wb = 1'b0; m_phase = 1'b0; m_hsd = 1'b0;
    pipe = {};
    pipe.push_back(z);
    exp_hs = 1'b0; exp_vs = 1'b0; exp_cv = 1'b1; exp_c = 0;
  endtask

  task automatic model_tick();
    bit   rise, fall, rb;
    int   len;
    ent_t nw, e;
    if (!ce_x2) return;
    rise = ce_x1 && hs_in && !m_hsd;
    fall = ce_x1 && !hs_in && m_hsd;
    rb   = !m_wb;
    nw.hs = (m_ocnt < m_hs_len);
    nw.vs = vs_in;
    nw.ph = m_phase;
    nw.v  = memv[rb][m_ocnt];
    nw.c  = 18'(mem[rb][m_ocnt]);
    e = pipe.pop_front();
    pipe.push_back(nw);
    exp_hs = e.hs;
    exp_vs = e.vs;
    if (e.hs) begin
      exp_cv = 1'b1;
      exp_c  = 0;
    end else begin
      exp_cv = e.v;
      exp_c  = (scanlines && e.ph) ? dim_rgb(e.c) : e.c;
    end
    len = (m_line_len == 0) ? NADDR : m_line_len;
    if (rise) begin
      m_ocnt = 0; m_phase = 1'b0;
    end else if (m_ocnt == len - 1) begin
      m_ocnt = 0; m_phase = !m_phase;
    end else begin
      m_ocnt = (m_ocnt + 1) % NADDR;
    end
    if (ce_x1) begin
      mem[m_wb][m_hcnt]  = {r_in, g_in, b_in};
      memv[m_wb][m_hcnt] = 1'b1;
      if (fall) m_hs_len = m_hcnt;
      if (rise) begin
        m_line_len = m_hcnt; m_hcnt = 0; m_wb = !m_wb;
      end else if (m_hcnt < NADDR - 1) begin
        m_hcnt++;
      end
      m_hsd = hs_in;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick(input bit xchk);
    @(negedge clk_sys);
    ce_x2 = (div % 2 == 0);
    ce_x1 = (div % 4 == 0);
    div++;
    @(posedge clk_sys);
    model_tick();
    #1;
    chk("hs_out", hs_out, exp_hs);
    chk("vs_out", vs_out, exp_vs);
    if (exp_cv) chk("rgb_out", {r_out, g_out, b_out}, exp_c);
    if (xchk) chk("no_x", $isunknown({hs_out, vs_out, r_out, g_out, b_out}), 0);
    if ({r_out, g_out, b_out} == 18'h30C30) seen_30++;
    if ({r_out, g_out, b_out} == 18'h030C3) seen_03++;
  endtask

  task automatic in_pixel(input bit hs, input bit vs, input logic [17:0] rgb, input bit xchk);
    hs_in = hs;
    vs_in = vs;
    {r_in, g_in, b_in} = rgb;
    repeat (4) tick(xchk);
  endtask

  // mode 0 ramp, 1 random, 2 constant 3F, 3 constant 04
  task automatic run_line(input int len, input int hsw, input int mode, input bit vs);
    logic [5:0]  p;
    logic [17:0] rgb;
    for (int i = 0; i < len; i++) begin
      p = 6'(i);
      case (mode)
        0:       rgb = {p, p, p};
        1:       rgb = 18'($urandom);
        2:       rgb = {6'h3F, 6'h3F, 6'h3F};
        default: rgb = {6'h04, 6'h04, 6'h04};
      endcase
      in_pixel(i < hsw, vs, rgb, 1'b0);
    end
  endtask

  // Reset is asserted between clock edges and outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    ce_x1 = 1'b0;
    ce_x2 = 1'b0;
    #1;
    chk("rst_hs", hs_out, 0);
    chk("rst_vs", vs_out, 0);
    chk("rst_rgb", {r_out, g_out, b_out}, 0);
    repeat (3) @(posedge clk_sys);
    #3;
    reset_n = 1'b1;
    div = 0;
    model_reset();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NADDR; a++) begin
        memv[b][a] = 1'b0;
        mem[b][a]  = 0;
      end
    model_reset();
    async_reset();

    scanlines = 1'b0;
    for (int l = 0; l < 4; l++) run_line(448, 32, 0, l == 1);

    scanlines = 1'b1;
    for (int l = 0; l < 3; l++) run_line(448, 32, 2, 1'b0);
    chk("dim_3f_seen", seen_30 > 0, 1);
    for (int l = 0; l < 3; l++) run_line(448, 32, 3, 1'b0);
    chk("dim_04_seen", seen_03 > 0, 1);

    for (int l = 0; l < 5; l++) begin
      scanlines = 1'($urandom);
      run_line((l < 2) ? 448 : 456, 32, 1, l == 3);
    end

    scanlines = 1'b0;
    run_line(200, 32, 1, 1'b0);
    async_reset();
    for (int l = 0; l < 4; l++) run_line(448, 32, 1, 1'b0);

    async_reset();
    for (int i = 0; i < 3000; i++) in_pixel(1'b0, 1'b0, 18'($urandom), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
